disp_sched: RTL and testbench

Display scheduler upstream of the 4-digit multiplexed scanner. Generates the scanner's scan-enable strobe, arbitrates the digit bus between the running-time source and the alarm source, and sequences the mode state machine for time setting, including blink of the field under edit and auto-return to time display. Sits between the clock/alarm counters and the digit scanner. All digit outputs are registered.

---
 rtl/disp_sched.sv | 153 +++++++++++++++
 tb/tb_disp_sched.sv | 139 +++++++++++++
 2 files changed

// File: rtl/disp_sched.sv
// rtl/disp_sched.sv - display scheduler: scan strobe, mode FSM, blink and digit bus arbitration
module disp_sched #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 250,
    parameter int TIMEOUT   = 40
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MODE_BTN,
    input  logic [3:0] T1,
    input  logic [3:0] T2,
    input  logic [3:0] T3,
    input  logic [3:0] T4,
    input  logic [3:0] A1,
    input  logic [3:0] A2,
    input  logic [3:0] A3,
    input  logic [3:0] A4,
    output logic       SCAN_EN,
    output logic [3:0] L1,
    output logic [3:0] L2,
    output logic [3:0] L3,
    output logic [3:0] L4,
    output logic       SET_H,
    output logic       SET_M,
    output logic       SHOW_ALARM
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_TIME     = 2'd0;
    localparam logic [1:0] ST_SET_HOUR = 2'd1;
    localparam logic [1:0] ST_SET_MIN  = 2'd2;
    localparam logic [1:0] ST_ALARM    = 2'd3;

    logic [PW-1:0] pre_cnt;
    logic [BW-1:0] blk_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          bp;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          blink_tick;
    logic          expire;
    logic          state_chg;
    logic          enter_edit;

    assign SCAN_EN    = (pre_cnt == PRE_MAX);
    assign blink_tick = SCAN_EN && (blk_cnt == BLK_MAX);
    assign expire     = (state != ST_TIME) && blink_tick && (tmo_cnt == TMO_MAX);

    // MODE_BTN outranks timeout expiry; the 2-bit increment wraps ALARM back to TIME
    always_comb begin
        state_nxt = state;
        if (MODE_BTN) begin
            state_nxt = state + 2'd1;
        end else if (expire) begin
            state_nxt = ST_TIME;
        end
    end

    assign state_chg  = (state_nxt != state);
    assign enter_edit = state_chg && ((state_nxt == ST_SET_HOUR) || (state_nxt == ST_SET_MIN));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre_cnt <= '0;
        end else if (SCAN_EN) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Entry into an edit state restarts the blink so it opens with a full visible half-period
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            blk_cnt <= '0;
            bp      <= 1'b0;
        end else if (enter_edit) begin
            blk_cnt <= '0;
            bp      <= 1'b0;
        end else if (SCAN_EN) begin
            if (blk_cnt == BLK_MAX) begin
                blk_cnt <= '0;
                bp      <= ~bp;
            end else begin
                blk_cnt <= blk_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmo_cnt <= '0;
            state   <= ST_TIME;
        end else begin
            state <= state_nxt;
            if (MODE_BTN || state_chg || (state == ST_TIME)) begin
                tmo_cnt <= '0;
            end else if (blink_tick) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            L1         <= 4'hF;
            L2         <= 4'hF;
            L3         <= 4'hF;
            L4         <= 4'hF;
            SET_H      <= 1'b0;
            SET_M      <= 1'b0;
            SHOW_ALARM <= 1'b0;
        end else begin
            SET_H      <= (state == ST_SET_HOUR);
            SET_M      <= (state == ST_SET_MIN);
            SHOW_ALARM <= (state == ST_ALARM);
            case (state)
                ST_SET_HOUR: begin
                    L4 <= bp ? 4'hF : T4;
                    L3 <= bp ? 4'hF : T3;
                    L2 <= T2;
                    L1 <= T1;
                end
                ST_SET_MIN: begin
                    L4 <= T4;
                    L3 <= T3;
                    L2 <= bp ? 4'hF : T2;
                    L1 <= bp ? 4'hF : T1;
                end
                ST_ALARM: begin
                    L4 <= A4;
                    L3 <= A3;
                    L2 <= A2;
                    L1 <= A1;
                end
                default: begin
                    L4 <= (T4 == 4'd0) ? 4'hF : T4;
                    L3 <= T3;
                    L2 <= T2;
                    L1 <= T1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_sched.sv
// tb/tb_disp_sched.sv - directed self-checking bench for disp_sched
module tb_disp_sched;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       MODE_BTN;
    logic [3:0] T1, T2, T3, T4;
    logic [3:0] A1, A2, A3, A4;
    logic       SCAN_EN;
    logic [3:0] L1, L2, L3, L4;
    logic       SET_H, SET_M, SHOW_ALARM;

    int total = 0;
    int bad   = 0;

    disp_sched #(.SCAN_DIV(4), .BLINK_DIV(2), .TIMEOUT(3)) dut (
        .CLK(CLK), .RESET(RESET), .MODE_BTN(MODE_BTN),
        .T1(T1), .T2(T2), .T3(T3), .T4(T4),
        .A1(A1), .A2(A2), .A3(A3), .A4(A4),
        .SCAN_EN(SCAN_EN),
        .L1(L1), .L2(L2), .L3(L3), .L4(L4),
        .SET_H(SET_H), .SET_M(SET_M), .SHOW_ALARM(SHOW_ALARM)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] lbus();
        return {L4, L3, L2, L1};
    endfunction

    function automatic logic [15:0] flags();
        return {13'd0, SET_H, SET_M, SHOW_ALARM};
    endfunction

    initial begin
        RESET    = 1'b1;
        MODE_BTN = 1'b0;
        {T4, T3, T2, T1} = 16'h0935;
        {A4, A3, A2, A1} = 16'h0730;
        step();
        step();
        chk("rst_l", lbus(), 16'hFFFF);
        chk("rst_flags", flags(), 16'h0);
        chk("rst_scan", {15'd0, SCAN_EN}, 16'h0);
        RESET = 1'b0;
        #1;
        chk("rel_l", lbus(), 16'hFFFF);
        chk("rel_scan", {15'd0, SCAN_EN}, 16'h0);

        // edges 1..12: strobe is the 4th, 8th, 12th cycle (high after edges 3, 7, 11)
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("scan_e%0d", k), {15'd0, SCAN_EN}, (k % 4 == 3) ? 16'h1 : 16'h0);
            if (k == 1) chk("lz_blank", lbus(), 16'hF935);
        end

        T4 = 4'd1;
        step();                                   // edge 13
        chk("lz_off", lbus(), 16'h1935);
        {T4, T3, T2, T1} = 16'h1234;
        step();                                   // edge 14
        chk("time_1234", lbus(), 16'h1234);
        step();                                   // edge 15
        MODE_BTN = 1'b1;
        step();                                   // edge 16: enter SET_HOUR
        MODE_BTN = 1'b0;
        chk("seth_lag", flags(), 16'h0);
        for (int j = 1; j <= 20; j++) begin       // edges 17..36
            step();
            chk($sformatf("blink_h%0d", j), lbus(), (((j - 1) / 8) % 2 == 1) ? 16'hFF34 : 16'h1234);
            if (j == 1) chk("seth_on", flags(), 16'h4);
        end
        step(); step(); step();                   // edges 37..39
        MODE_BTN = 1'b1;
        step();                                   // edge 40: expiry and MODE_BTN collide
        MODE_BTN = 1'b0;
        chk("coll_lag", flags(), 16'h4);
        step();                                   // edge 41
        chk("coll_setm", flags(), 16'h2);
        chk("setm_vis", lbus(), 16'h1234);
        for (int j = 42; j <= 48; j++) step();
        chk("setm_vis48", lbus(), 16'h1234);
        step();                                   // edge 49
        chk("setm_blank", lbus(), 16'h12FF);
        for (int j = 50; j <= 64; j++) step();
        chk("tmo_lag", flags(), 16'h2);
        step();                                   // edge 65
        chk("tmo_time", flags(), 16'h0);
        chk("tmo_l", lbus(), 16'h1234);
        step(); step();                           // edges 66, 67
        MODE_BTN = 1'b1;
        step();                                   // edge 68
        chk("cyc_lag", flags(), 16'h0);
        step();                                   // edge 69
        chk("cyc_seth", flags(), 16'h4);
        step();                                   // edge 70
        chk("cyc_setm", flags(), 16'h2);
        step();                                   // edge 71
        MODE_BTN = 1'b0;
        chk("cyc_alarm", flags(), 16'h1);
        chk("alarm_l", lbus(), 16'h0730);
        step();                                   // edge 72
        chk("cyc_time", flags(), 16'h0);
        chk("cyc_time_l", lbus(), 16'h1234);
        step(); step(); step();                   // edges 73..75
        MODE_BTN = 1'b1;
        step();                                   // edge 76
        MODE_BTN = 1'b0;
        for (int j = 77; j <= 86; j++) step();
        chk("mid_blink", lbus(), 16'hFF34);
        RESET = 1'b1;
        #1;
        chk("arst_l", lbus(), 16'hFFFF);
        chk("arst_flags", flags(), 16'h0);
        chk("arst_scan", {15'd0, SCAN_EN}, 16'h0);
        for (int j = 0; j < 6; j++) begin
            step();
            chk($sformatf("hold_scan%0d", j), {15'd0, SCAN_EN}, 16'h0);
        end
        chk("hold_l", lbus(), 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
